// File: rtl/lock_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the lock attempt sequencer.
package lock_pkg;

  // Width of one keypad / core digit.
  localparam int unsigned DIGIT_W = 4;
  // Width of the consecutive-failure counter (MAX_FAILS never exceeds 3).
  localparam int unsigned FAILS_W = 2;

  // Default parameter values for lock_sequencer.
  localparam int unsigned DEF_DIGITS         = 4;
  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_ENTRY_TIMEOUT  = 200;
  localparam int unsigned DEF_UNLOCK_CYCLES  = 500;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;

  // Attempt FSM encoding. Plain constants keep the encoding visible to
  // older tools and waveform viewers.
  typedef logic [2:0] state_t;
  localparam state_t S_CLEAR   = 3'd0;
  localparam state_t S_IDLE    = 3'd1;
  localparam state_t S_ENTRY   = 3'd2;
  localparam state_t S_WAIT    = 3'd3;
  localparam state_t S_CHECK   = 3'd4;
  localparam state_t S_OPEN    = 3'd5;
  localparam state_t S_LOCKOUT = 3'd6;

  // Largest of three cycle counts; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Keypad-side and core-side signals of the lock sequencer, plus status outputs.
// master = the sequencer, slave = its surroundings (keypad, core, status sink).
interface lock_sequencer_if;
  import lock_pkg::*;

  // Keypad front end
  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               key_ready;

  // Combination lock core
  logic               lock_enter;
  logic [DIGIT_W-1:0] lock_digit;
  logic               lock_reset;
  logic               lock_unlocked;

  // Status
  logic               unlocked;
  logic               locked_out;
  logic               fail;
  logic [FAILS_W-1:0] fails;

  modport master (
    input  key_valid,
    input  key_digit,
    output key_ready,
    output lock_enter,
    output lock_digit,
    output lock_reset,
    input  lock_unlocked,
    output unlocked,
    output locked_out,
    output fail,
    output fails
  );

  modport slave (
    output key_valid,
    output key_digit,
    input  key_ready,
    input  lock_enter,
    input  lock_digit,
    input  lock_reset,
    output lock_unlocked,
    input  unlocked,
    input  locked_out,
    input  fail,
    input  fails
  );

endinterface

// File: rtl/lock_seq_timer.sv
// Clearable saturating up-counter with a terminal-count compare. 'last' is high
// in the cycle whose increment would make the count reach 'limit'.
module lock_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins over enable; hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == (limit - W'(1)));

endmodule

// File: rtl/lock_sequencer.sv
// Attempt controller between the keypad and the 4-digit lock core: forwards keys,
// counts digits, checks the core's verdict, re-arms the core after each attempt,
// and handles failure lockout, entry timeout and automatic re-lock.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS         = DEF_DIGITS,
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT,
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  lock_sequencer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned TW    =
      $clog2(max3(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   DIGITS_C    = CNT_W'(DIGITS);
  localparam logic [FAILS_W-1:0] MAX_FAILS_C = FAILS_W'(MAX_FAILS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_enter_q, lock_enter_d;
  logic [DIGIT_W-1:0] lock_digit_q, lock_digit_d;
  logic               fail_q, fail_d;
  logic [FAILS_W-1:0] fails_q, fails_d;

  logic               key_ready;
  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FAILS_W-1:0] fails_inc;

  logic               tmr_clr;
  logic               tmr_en;
  logic [TW-1:0]      tmr_limit;
  logic               tmr_last;

  assign key_ready = (state_q == S_IDLE) || (state_q == S_ENTRY);
  assign accept    = bus.key_valid && key_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign fails_inc = (fails_q >= MAX_FAILS_C) ? fails_q : (fails_q + FAILS_W'(1));

  // One timer serves ENTRY (idle timeout), OPEN and LOCKOUT; it is held at zero
  // elsewhere so each of those states starts counting from zero.
  always_comb begin
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
    tmr_limit = TW'(ENTRY_TIMEOUT);
    case (state_q)
      S_ENTRY: begin
        // An accepted key restarts the idle window, even on the timeout cycle.
        tmr_clr = accept;
        tmr_en  = !accept;
      end
      S_OPEN: begin
        tmr_clr   = 1'b0;
        tmr_en    = 1'b1;
        tmr_limit = TW'(UNLOCK_CYCLES);
      end
      S_LOCKOUT: begin
        tmr_clr   = 1'b0;
        tmr_en    = 1'b1;
        tmr_limit = TW'(LOCKOUT_CYCLES);
      end
      default: ;
    endcase
  end

  lock_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .last  (tmr_last)
  );

  // Attempt FSM, digit counting, key forwarding and failure bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_enter_d = accept;
    lock_digit_d = accept ? bus.key_digit : lock_digit_q;
    fail_d       = 1'b0;
    fails_d      = fails_q;

    case (state_q)
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DIGITS_C) state_d = S_WAIT;
        end else if (tmr_last) begin
          // Abandoned entry: re-arm the core without counting a failure.
          state_d = S_CLEAR;
        end
      end
      S_WAIT: begin
        // Core consumes the last digit this cycle.
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.lock_unlocked) begin
          fails_d = '0;
          state_d = S_OPEN;
        end else begin
          fail_d  = 1'b1;
          fails_d = fails_inc;
          state_d = (fails_inc == MAX_FAILS_C) ? S_LOCKOUT : S_CLEAR;
        end
      end
      S_OPEN: begin
        if (tmr_last) state_d = S_CLEAR;
      end
      S_LOCKOUT: begin
        if (tmr_last) begin
          fails_d = '0;
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // State and registered outputs; reset leaves the core held in reset via CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      lock_enter_q <= 1'b0;
      lock_digit_q <= '0;
      fail_q       <= 1'b0;
      fails_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_enter_q <= lock_enter_d;
      lock_digit_q <= lock_digit_d;
      fail_q       <= fail_d;
      fails_q      <= fails_d;
    end
  end

  assign bus.key_ready  = key_ready;
  assign bus.lock_enter = lock_enter_q;
  assign bus.lock_digit = lock_digit_q;
  assign bus.lock_reset = (state_q == S_CLEAR);
  assign bus.unlocked   = (state_q == S_OPEN);
  assign bus.locked_out = (state_q == S_LOCKOUT);
  assign bus.fail       = fail_q;
  assign bus.fails      = fails_q;

  // The core must never see an enter strobe while it is being reset.
  a_enter_not_reset: assert property (@(posedge clk) disable iff (!reset)
    !(bus.lock_enter && bus.lock_reset));

  // Keys offered while not ready are dropped.
  a_drop_key: assert property (@(posedge clk) disable iff (!reset)
    (bus.key_valid && !key_ready) |=> !bus.lock_enter);

  // The failure count never passes its limit.
  a_fails_bound: assert property (@(posedge clk) disable iff (!reset)
    fails_q <= MAX_FAILS_C);

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: cycle table after reset, directed corner sequences,
// then random keys checked every cycle against an attempt-level reference model.
module tb_lock_sequencer;
  import lock_pkg::*;

  localparam int NDIG  = 4;
  localparam int MAXF  = 3;
  localparam int ETO   = 10;
  localparam int UNLK  = 8;
  localparam int LKOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kv;
  logic [3:0] kd;

  int n_checks = 0;
  int n_errors = 0;

  lock_sequencer_if bus ();

  lock_sequencer #(
    .DIGITS         (NDIG),
    .MAX_FAILS      (MAXF),
    .ENTRY_TIMEOUT  (ETO),
    .UNLOCK_CYCLES  (UNLK),
    .LOCKOUT_CYCLES (LKOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.key_valid = kv;
  assign bus.key_digit = kd;

  // Behavioural lock core: stores digits, unlocked once the stored code matches.
  logic [3:0] code [4];
  logic [3:0] core_buf [4];
  int         core_n = 0;

  always @(posedge clk) begin
    if (bus.lock_reset) begin
      core_n <= 0;
    end else if (bus.lock_enter && core_n < 4) begin
      core_buf[core_n] <= bus.lock_digit;
      core_n <= core_n + 1;
    end
  end

  assign bus.lock_unlocked = (core_n == 4) && (core_buf[0] == code[0]) &&
                             (core_buf[1] == code[1]) && (core_buf[2] == code[2]) &&
                             (core_buf[3] == code[3]);

  // Attempt-level reference model: remaining-cycle counters for each phase and
  // the list of digits typed so far.
  int         m_clear, m_open, m_lock, m_pipe, m_idle, m_fails;
  int         m_q [$];
  logic       m_enter, m_fail;
  logic [3:0] m_digit;

  function automatic void model_reset();
    m_clear = 1; m_open = 0; m_lock = 0; m_pipe = 0; m_idle = 0; m_fails = 0;
    m_q.delete();
    m_enter = 1'b0; m_fail = 1'b0; m_digit = 4'd0;
  endfunction

  function automatic bit code_ok();
    if (m_q.size() != NDIG) return 1'b0;
    for (int i = 0; i < NDIG; i++) if (m_q[i] != int'(code[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input logic k_v, input logic [3:0] k_d);
    m_enter = 1'b0;
    m_fail  = 1'b0;
    if (m_clear > 0) begin
      m_clear = 0; m_idle = 0; m_q.delete();
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin m_fails = 0; m_clear = 1; end
    end else if (m_open > 0) begin
      m_open--;
      if (m_open == 0) m_clear = 1;
    end else if (m_pipe == 1) begin
      m_pipe = 2;
    end else if (m_pipe == 2) begin
      m_pipe = 0;
      if (code_ok()) begin
        m_fails = 0; m_open = UNLK;
      end else begin
        m_fails++; m_fail = 1'b1;
        if (m_fails >= MAXF) begin m_fails = MAXF; m_lock = LKOUT; end
        else m_clear = 1;
      end
    end else if (k_v) begin
      m_q.push_back(int'(k_d));
      m_idle = 0; m_enter = 1'b1; m_digit = k_d;
      if (m_q.size() == NDIG) m_pipe = 1;
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle >= ETO) m_clear = 1;
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // {ready, enter, digit[3:0], lock_reset, unlocked, locked_out, fail, fails[1:0]}
  function automatic logic [11:0] outs();
    return {bus.key_ready, bus.lock_enter, bus.lock_digit, bus.lock_reset, bus.unlocked,
            bus.locked_out, bus.fail, bus.fails};
  endfunction

  function automatic logic [11:0] model_outs();
    logic rdy;
    rdy = (m_clear == 0) && (m_lock == 0) && (m_open == 0) && (m_pipe == 0);
    return {rdy, m_enter, m_digit, (m_clear > 0), (m_open > 0), (m_lock > 0), m_fail,
            2'(m_fails)};
  endfunction

  // One clock: DUT and model both take the inputs, then all outputs are compared.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(kv, kd);
    #1;
    chk("outputs", 32'(outs()), 32'(model_outs()));
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
    logic [3:0] ds [4];
    ds = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      kv = 1'b1; kd = ds[i]; tick();
      kv = 1'b0; tick();
    end
  endtask

  task automatic wait_relock();
    bit seen;
    seen = 1'b0;
    kv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.lock_reset) begin seen = 1'b1; break; end
    end
    chk("relock_seen", 32'(seen), 32'd1);
    chk("relock_unlocked", 32'(bus.unlocked), 32'd0);
    tick();
  endtask

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       ready;
    logic       enter;
    logic       rst;
    logic       unl;
  } vec_t;

  function automatic vec_t row(input logic v, input logic [3:0] d, input logic r,
                               input logic e, input logic s, input logic u);
    vec_t t;
    t.kv = v; t.kd = d; t.ready = r; t.enter = e; t.rst = s; t.unl = u;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [19];
    int          n, enters;
    bit          seen_fail;
    int unsigned rate;

    code = '{4'd9, 4'd9, 4'd7, 4'd9};
    kv = 1'b0; kd = 4'd0;
    model_reset();

    // Correct code from reset release: keys on edges 2,4,6,8, open for 8 cycles.
    tbl[0] = row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1] = row(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[2] = row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3] = row(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4] = row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5] = row(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[6] = row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7] = row(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8] = row(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 9; i < 17; i++) tbl[i] = row(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[17] = row(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[18] = row(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick(); tick();
    chk("reset_state", 32'(outs()), 32'h020);
    reset = 1'b1;
    #1;
    chk("first_cycle_clear", 32'({bus.lock_reset, bus.key_ready}), 32'b10);

    for (int i = 0; i < 19; i++) begin
      kv = tbl[i].kv; kd = tbl[i].kd;
      tick();
      chk($sformatf("vec%0d", i),
          32'({bus.key_ready, bus.lock_enter, bus.lock_reset, bus.unlocked}),
          32'({tbl[i].ready, tbl[i].enter, tbl[i].rst, tbl[i].unl}));
    end
    kv = 1'b0;

    // Wrong code: one fail pulse, fails=1, one lock_reset, then ready
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    chk("wrong_fail_pulse", 32'({bus.fail, bus.fails, bus.lock_reset}), 32'b1011);
    tick();
    chk("wrong_after", 32'({bus.fail, bus.lock_reset, bus.key_ready}), 32'b001);

    // Entry timeout: 9,9 then idle; lock_reset after 10 idle cycles, fails kept
    kv = 1'b1; kd = 4'd9; tick();
    kv = 1'b0; tick();
    kv = 1'b1; kd = 4'd9; tick();
    kv = 1'b0;
    n = 0; seen_fail = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (bus.fail) seen_fail = 1'b1;
      if (bus.lock_reset) break;
    end
    chk("timeout_cycles", 32'(n), 32'd10);
    chk("timeout_no_fail", 32'(seen_fail), 32'd0);
    chk("timeout_fails_kept", 32'(bus.fails), 32'd1);
    tick();
    chk("timeout_ready", 32'(bus.key_ready), 32'd1);
    enter4(4'd9, 4'd9, 4'd7, 4'd9);
    tick();
    chk("after_timeout_unlock", 32'({bus.unlocked, bus.fails}), 32'b100);
    wait_relock();

    // Three wrong attempts -> lockout for 16 cycles, keys ignored, fails cleared
    for (int a = 0; a < 3; a++) begin
      enter4(4'd1, 4'd2, 4'd3, 4'd4);
      tick();
      if (a < 2) tick();
    end
    chk("lockout_enter", 32'({bus.locked_out, bus.fail, bus.fails}), 32'b1111);
    n = 1; enters = 0;
    for (int i = 0; i < 40; i++) begin
      kv = 1'(i % 2); kd = 4'd5;
      tick();
      if (bus.lock_enter) enters++;
      if (!bus.locked_out) break;
      n++;
    end
    kv = 1'b0;
    chk("lockout_cycles", 32'(n), 32'd16);
    chk("lockout_no_enter", 32'(enters), 32'd0);
    chk("lockout_exit", 32'({bus.fails, bus.lock_reset}), 32'b001);
    tick();

    // Keys during WAIT and OPEN are dropped and do not disturb the digit count
    for (int i = 0; i < 3; i++) begin
      kv = 1'b1; kd = code[i]; tick();
      kv = 1'b0; tick();
    end
    kv = 1'b1; kd = 4'd9; tick();
    chk("last_key_enter", 32'({bus.lock_enter, bus.key_ready}), 32'b10);
    kd = 4'd3; tick();
    chk("drop_in_wait", 32'(bus.lock_enter), 32'd0);
    tick();
    chk("drop_in_check", 32'({bus.lock_enter, bus.unlocked}), 32'b01);
    enters = 0;
    for (int i = 0; i < 20; i++) begin
      kv = 1'(i % 2 == 0); kd = 4'(i);
      tick();
      if (bus.lock_enter) enters++;
      if (bus.lock_reset) break;
    end
    kv = 1'b0;
    chk("drop_in_open", 32'(enters), 32'd0);
    tick();
    enter4(4'd9, 4'd9, 4'd7, 4'd9);
    tick();
    chk("count_unaffected", 32'(bus.unlocked), 32'd1);
    wait_relock();

    // Asynchronous reset after the 3rd digit of a correct code
    for (int i = 0; i < 3; i++) begin
      kv = 1'b1; kd = code[i]; tick();
      kv = 1'b0; tick();
    end
    reset = 1'b0;
    #1;
    chk("async_reset_values", 32'(outs()), 32'h020);
    model_reset();
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("release_clear", 32'(bus.lock_reset), 32'd1);
    tick();
    enter4(4'd9, 4'd9, 4'd7, 4'd9);
    tick();
    chk("unlock_after_reset", 32'(bus.unlocked), 32'd1);
    wait_relock();

    // Random keys, biased toward the right code, with varying key density
    rate = 25;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 3;
          1:       rate = 25;
          default: rate = 70;
        endcase
      end
      kv = ($urandom_range(0, 99) < rate);
      if ($urandom_range(0, 3) != 0 && m_q.size() < NDIG) kd = code[m_q.size()];
      else kd = 4'($urandom_range(0, 15));
      tick();
    end
    kv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Attempt controller that sits between the keypad front end and the 4-digit combination lock core. Forwards key presses to the core, tracks digit count, and checks the core's unlocked flag after the last digit. Re-arms the core by pulsing its reset after every attempt. Also counts consecutive failures, enforces a lockout period, times out abandoned entries and re-locks automatically after an open period.

## Interface
- DIGITS, 4: digits per attempt; legal range 2..8.
- MAX_FAILS, 3: consecutive failures that trigger lockout; legal range 1..3.
- ENTRY_TIMEOUT, 200: idle cycles in ENTRY before the attempt is abandoned.
- UNLOCK_CYCLES, 500: cycles spent in OPEN before automatic re-lock.
- LOCKOUT_CYCLES, 1000: cycles spent in LOCKOUT.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. The block is in reset while `reset`=0.
- key_valid  in  1  one-cycle strobe; a key is present on key_digit.
- key_digit  in  4  key value 0..15.
- key_ready  out  1  high when a key_valid in this cycle will be accepted.
- lock_enter  out  1  enter strobe to the core.
- lock_digit  out  4  digit to the core.
- lock_reset  out  1  active-high reset to the core.
- lock_unlocked  in  1  unlocked flag from the core.
- unlocked  out  1  access granted.
- locked_out  out  1  lockout active.
- fail  out  1  one-cycle pulse per failed attempt.
- fails  out  2  consecutive failure count.

## Operation
- All outputs are registered. unlocked, locked_out, key_ready and lock_reset decode from the registered state.
- Reset values:
  - key_ready=0, lock_enter=0, lock_digit=0, lock_reset=1.
  - unlocked=0, locked_out=0, fail=0, fails=0.
  - State=CLEAR; digit count and timer are 0.
- CLEAR:
  - lock_reset=1 and key_ready=0 for exactly one cycle.
  - Timer and digit count are cleared.
  - Next state is IDLE.
- IDLE:
  - key_ready=1.
  - On key_valid: register lock_enter=1 and lock_digit=key_digit for the next cycle, set count=1, go to ENTRY.
- ENTRY:
  - key_ready=1.
  - Each key_valid is forwarded the same way, increments count and clears the timer.
  - When the key that makes count=DIGITS is accepted, go to WAIT.
  - With no key, the timer increments. On reaching ENTRY_TIMEOUT, go to CLEAR; fails is unchanged and no fail pulse is issued.
- WAIT:
  - One cycle, key_ready=0, while the core consumes the last digit.
  - Next state is CHECK.
- CHECK: one cycle, samples lock_unlocked.
  - If lock_unlocked=1: fails←0, go to OPEN.
  - Otherwise: fail pulse next cycle and fails←fails+1.
  - After a failure, go to LOCKOUT if the new count equals MAX_FAILS, else go to CLEAR.
- OPEN:
  - unlocked=1 and key_ready=0.
  - The timer counts up. At UNLOCK_CYCLES, go to CLEAR.
- LOCKOUT:
  - locked_out=1 and key_ready=0.
  - At LOCKOUT_CYCLES: fails←0, go to CLEAR.
- key_valid while key_ready=0 is dropped; lock_enter stays 0.
- lock_enter is high for exactly one cycle per accepted key and is never high in the same cycle as lock_reset.

## Timing
- Last key_valid sampled at cycle N:
  - lock_enter=1 in N+1 (WAIT).
  - CHECK in N+2.
  - unlocked=1 or fail=1 in N+3.
- After a failure or timeout, key_ready returns 2 cycles after leaving CHECK/ENTRY (CLEAR, then IDLE).
- Timer width is $clog2 of the maximum of the three cycle parameters, plus 1. The timer saturates and never wraps.
- fails saturates at MAX_FAILS.
- Simultaneous events:
  - key_valid in the cycle ENTRY_TIMEOUT is reached: the key wins, is accepted and clears the timer.
  - Timeout and the last digit together: go to WAIT.
- Reset asserted mid-operation: every output takes its reset value immediately (asynchronously). lock_reset holds the core in reset, and fails is lost.
- After reset deassertion, the first cycle is CLEAR.

## Structure
- Package lock_pkg holds:
  - the state enumeration: CLEAR, IDLE, ENTRY, WAIT, CHECK, OPEN, LOCKOUT;
  - the default parameter constants;
  - the DIGIT_W=4 width constant.
- One sub-module: lock_seq_timer, a clearable saturating up-counter with a terminal-count compare. The top instantiates it once; the timer is shared by ENTRY, OPEN and LOCKOUT.
- The lock core is instantiated beside this block by the top level, not inside it.

## Test plan
For all scenarios: core code 9,9,7,9; UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, ENTRY_TIMEOUT=10.
- Release reset, keys 9,9,7,9 at cycles 2,4,6,8:
  - unlocked=1 at cycle 11, fails=0.
  - Auto re-lock after 8 cycles: unlocked=0 and a lock_reset pulse.
- Keys 1,2,3,4:
  - fail high for exactly 1 cycle, fails=1.
  - One lock_reset pulse, then key_ready=1.
- Three wrong attempts:
  - locked_out=1 for 16 cycles.
  - Keys pressed during lockout produce no lock_enter.
  - On exit, fails=0.
- Keys 9,9 then idle:
  - After 10 cycles, a lock_reset pulse.
  - fails unchanged, no fail pulse.
  - A correct 4-digit entry afterwards unlocks.
- Drive reset=0 after the 3rd digit of a correct code:
  - Outputs take reset values within the cycle, lock_reset=1.
  - After release, the full code unlocks.
- key_valid pulses during OPEN and WAIT: dropped; lock_enter stays 0 and the digit count is unaffected.
